// File: rtl/btb_assoc_file.sv
// Set-associative branch target buffer with 2-bit direction counters,
// per-set LRU replacement, same-cycle update bypass and a sequential flush.
module btb_assoc_file #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int TARGET_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         lookup_pc,
  output logic                hit,
  output logic                predict_taken,
  output logic [TARGET_W-1:0] predict_target,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [TARGET_W-1:0] upd_target,
  input  logic                flush_req,
  output logic                flush_busy
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] flush_cnt;

  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TARGET_W-1:0] tgt_q   [SETS][WAYS];
  logic [1:0]          cnt_q   [SETS][WAYS];
  logic                lru_q   [SETS];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_en;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_en  = (state_q == IDLE) && upd_valid && !flush_req;

  // Post-update image of the set addressed by upd_pc
  logic                n_valid [WAYS];
  logic [TAG_W-1:0]    n_tag   [WAYS];
  logic [TARGET_W-1:0] n_tgt   [WAYS];
  logic [1:0]          n_cnt   [WAYS];
  logic                n_lru;
  logic                up_hit;
  int                  hw;
  int                  vic;

  always_comb begin
    up_hit = 1'b0;
    hw     = 0;
    vic    = 0;
    n_lru  = lru_q[up_idx];
    for (int w = 0; w < WAYS; w++) begin
      n_valid[w] = valid_q[up_idx][w];
      n_tag[w]   = tag_q[up_idx][w];
      n_tgt[w]   = tgt_q[up_idx][w];
      n_cnt[w]   = cnt_q[up_idx][w];
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        hw     = w;
      end
    end
    if (up_en && up_hit) begin
      if (upd_taken) begin
        if (n_cnt[hw] != 2'b11) n_cnt[hw] = n_cnt[hw] + 2'd1;
        n_tgt[hw] = upd_target;
      end else if (n_cnt[hw] != 2'b00) begin
        n_cnt[hw] = n_cnt[hw] - 2'd1;
      end
      n_lru = (WAYS == 2) ? (hw == 0) : 1'b0;
    end else if (up_en && upd_taken) begin
      vic = (WAYS == 2) ? int'(lru_q[up_idx]) : 0;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!valid_q[up_idx][w]) vic = w;
      end
      n_valid[vic] = 1'b1;
      n_tag[vic]   = up_tag;
      n_tgt[vic]   = upd_target;
      n_cnt[vic]   = 2'b10;
      n_lru        = (WAYS == 2) ? (vic == 0) : 1'b0;
    end
  end

  // Lookup sees the updated set when indices collide
  logic                byp;
  logic                e_valid;
  logic [TAG_W-1:0]    e_tag;
  logic [TARGET_W-1:0] e_tgt;
  logic [1:0]          e_cnt;

  assign byp = up_en && (up_idx == lk_idx);

  always_comb begin
    hit            = 1'b0;
    predict_taken  = 1'b0;
    predict_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      e_valid = byp ? n_valid[w] : valid_q[lk_idx][w];
      e_tag   = byp ? n_tag[w]   : tag_q[lk_idx][w];
      e_tgt   = byp ? n_tgt[w]   : tgt_q[lk_idx][w];
      e_cnt   = byp ? n_cnt[w]   : cnt_q[lk_idx][w];
      if (state_q == IDLE && e_valid && e_tag == lk_tag) begin
        hit            = 1'b1;
        predict_taken  = e_cnt[1];
        predict_target = e_tgt;
      end
    end
  end

  assign flush_busy = (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (flush_req) state_d = FLUSH;
      FLUSH: if (flush_cnt == IDX_W'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flush_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          cnt_q[s][w]   <= 2'b00;
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH) begin
        flush_cnt        <= flush_cnt + 1'b1;
        lru_q[flush_cnt] <= 1'b0;
        for (int w = 0; w < WAYS; w++) valid_q[flush_cnt][w] <= 1'b0;
      end else if (up_en) begin
        lru_q[up_idx] <= n_lru;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[up_idx][w] <= n_valid[w];
          tag_q[up_idx][w]   <= n_tag[w];
          tgt_q[up_idx][w]   <= n_tgt[w];
          cnt_q[up_idx][w]   <= n_cnt[w];
        end
      end
    end
  end

endmodule
